// File: rtl/radix_butterfly_pipe.sv
// Pipelined radix-2^LOG_R NTT/INTT butterfly: LOG_R radix-2 stages, each two elastic slots.
// Optional INTT output scaling by INV_R when RADIX_BUTTERFLY_SCALE_EN is defined.

module radix_mod_mul #(
  parameter int WIDTH = 13,
  parameter int Q     = 7681
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  localparam logic [2*WIDTH-1:0] QM = (2*WIDTH)'(Q);
  logic [2*WIDTH-1:0] prod;

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign p    = WIDTH'(prod % QM);
endmodule

// One physical radix-2 stage. Slot A: NTT multiply / INTT add-sub.
// Slot B: NTT add-sub / INTT multiply of the registered difference.
module radix_butterfly_stage #(
  parameter int WIDTH = 13,
  parameter int Q     = 7681,
  parameter int LOG_R = 3,
  parameter int P     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 ready_a,
  input  logic                                 ready_b,
  input  logic                                 in_mode,
  input  logic [(1<<LOG_R)*WIDTH-1:0]          in_data,
  input  logic [((1<<LOG_R)-1)*WIDTH-1:0]      in_tw,
  output logic                                 valid_a,
  output logic                                 valid_b,
  output logic                                 out_mode,
  output logic [(1<<LOG_R)*WIDTH-1:0]          out_data,
  output logic [((1<<LOG_R)-1)*WIDTH-1:0]      out_tw
);
  localparam int R   = 1 << LOG_R;
  localparam int S_N = P;
  localparam int S_I = LOG_R - 1 - P;
  localparam int D_N = R >> (S_N + 1);
  localparam int D_I = R >> (S_I + 1);
  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return s[WIDTH-1:0];
  endfunction

  // A negative difference wraps with the top bit set; adding Q wraps it back into range.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[WIDTH]) s = s + QX;
    return s[WIDTH-1:0];
  endfunction

  logic [R-1:0][WIDTH-1:0] x, nxt_a, ya, nxt_b, yb;
  logic [R-2:0][WIDTH-1:0] t, ta, tb;
  logic                    ma, mb;

  assign x = in_data;
  assign t = in_tw;

  for (genvar i = 0; i < R; i++) begin : g_lane
    localparam int GN   = i / (2 * D_N);
    localparam bit LO_N = (i % (2 * D_N)) < D_N;
    localparam int PN   = LO_N ? i + D_N : i - D_N;
    localparam int TN   = (1 << S_N) - 1 + GN;
    localparam int GI   = i / (2 * D_I);
    localparam bit LO_I = (i % (2 * D_I)) < D_I;
    localparam int PI   = LO_I ? i + D_I : i - D_I;
    localparam int TI   = (1 << S_I) - 1 + GI;

    logic [WIDTH-1:0] a_ntt, b_intt;

    if (LO_N) begin : g_ntt_lo
      assign a_ntt = x[i];
    end else begin : g_ntt_hi
      radix_mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(x[i]), .b(t[TN]), .p(a_ntt));
    end

    if (LO_I) begin : g_intt_lo
      assign b_intt = ya[i];
    end else begin : g_intt_hi
      radix_mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(ya[i]), .b(ta[TI]), .p(b_intt));
    end

    assign nxt_a[i] = in_mode ? (LO_I ? mod_add(x[i], x[PI]) : mod_sub(x[PI], x[i])) : a_ntt;
    assign nxt_b[i] = ma ? b_intt : (LO_N ? mod_add(ya[i], ya[PN]) : mod_sub(ya[PN], ya[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_a <= 1'b0;
      ma      <= 1'b0;
      ya      <= '0;
      ta      <= '0;
    end else if (ready_a) begin
      valid_a <= in_valid;
      if (in_valid) begin
        ma <= in_mode;
        ya <= nxt_a;
        ta <= t;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_b <= 1'b0;
      mb      <= 1'b0;
      yb      <= '0;
      tb      <= '0;
    end else if (ready_b) begin
      valid_b <= valid_a;
      if (valid_a) begin
        mb <= ma;
        yb <= nxt_b;
        tb <= ta;
      end
    end
  end

  assign out_mode = mb;
  assign out_data = yb;
  assign out_tw   = tb;
endmodule

module radix_butterfly_pipe #(
  parameter int WIDTH = 13,
  parameter int Q     = 7681,
  parameter int LOG_R = 3,
  parameter int INV_R = 6721
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_mode,
  input  logic [(1<<LOG_R)*WIDTH-1:0]       in_data,
  input  logic [((1<<LOG_R)-1)*WIDTH-1:0]   in_tw,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [(1<<LOG_R)*WIDTH-1:0]       out_data
);
  localparam int R  = 1 << LOG_R;
  localparam int DW = R * WIDTH;
  localparam int TW = (R - 1) * WIDTH;
`ifdef RADIX_BUTTERFLY_SCALE_EN
  localparam int SCALE = 1;
`else
  localparam int SCALE = 0;
`endif
  localparam int NS = 2 * LOG_R + SCALE;

  logic [NS:0]             vld_pipe;
  logic [NS-1:0]           rdy;
  logic [LOG_R:0]          mode_c;
  logic [LOG_R:0][DW-1:0]  data_c;
  logic [LOG_R:0][TW-1:0]  tw_c;

  assign vld_pipe[0] = in_valid;
  assign mode_c[0]   = in_mode;
  assign data_c[0]   = in_data;
  assign tw_c[0]     = in_tw;

  // A slot can load iff some slot at or after it is empty, or the output drains this cycle.
  for (genvar k = 0; k < NS; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&vld_pipe[NS:k+1]);
  end
  assign in_ready = rdy[0];

  for (genvar p = 0; p < LOG_R; p++) begin : g_stage
    radix_butterfly_stage #(.WIDTH(WIDTH), .Q(Q), .LOG_R(LOG_R), .P(p)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld_pipe[2*p]),
      .ready_a  (rdy[2*p]),
      .ready_b  (rdy[2*p+1]),
      .in_mode  (mode_c[p]),
      .in_data  (data_c[p]),
      .in_tw    (tw_c[p]),
      .valid_a  (vld_pipe[2*p+1]),
      .valid_b  (vld_pipe[2*p+2]),
      .out_mode (mode_c[p+1]),
      .out_data (data_c[p+1]),
      .out_tw   (tw_c[p+1])
    );
  end

`ifdef RADIX_BUTTERFLY_SCALE_EN
  localparam logic [WIDTH-1:0] INV_W = WIDTH'(INV_R);
  logic [R-1:0][WIDTH-1:0] yl, ysc, ys;
  logic [TW-1:0]           unused_bits;

  assign yl = data_c[LOG_R];
  for (genvar i = 0; i < R; i++) begin : g_scale
    radix_mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(yl[i]), .b(INV_W), .p(ysc[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[NS] <= 1'b0;
      ys           <= '0;
    end else if (rdy[NS-1]) begin
      vld_pipe[NS] <= vld_pipe[NS-1];
      if (vld_pipe[NS-1]) ys <= mode_c[LOG_R] ? ysc : yl;
    end
  end

  assign out_data    = ys;
  assign unused_bits = tw_c[LOG_R];
`else
  logic [TW+WIDTH:0] unused_bits;

  assign out_data    = data_c[LOG_R];
  assign unused_bits = {mode_c[LOG_R], tw_c[LOG_R], WIDTH'(INV_R)};
`endif

  assign out_valid = vld_pipe[NS];
endmodule

// File: tb/tb_radix_butterfly_pipe.sv
// Bench for radix_butterfly_pipe: radix-2 and radix-8 instances, vector table,
// elastic stall stream against a scoreboard, and mid-flight reset.
module tb_radix_butterfly_pipe;
  localparam int W = 13;
  localparam int Q = 7681;
`ifdef RADIX_BUTTERFLY_SCALE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int INV1 = 3841;
  localparam int INV3 = 6721;
  localparam int CAP3 = 6 + EXTRA;

  typedef struct packed {
    logic               l3;
    logic               mode;
    logic [7:0][W-1:0]  x;
    logic [6:0][W-1:0]  t;
    logic [7:0][W-1:0]  y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, in_mode = 1'b0, sel3 = 1'b0;
  logic [7:0][W-1:0] xd = '0;
  logic [6:0][W-1:0] td = '0;
  logic ir1, ov1, ir3, ov3;
  logic [2*W-1:0] od1;
  logic [8*W-1:0] od3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  radix_butterfly_pipe #(.WIDTH(W), .Q(Q), .LOG_R(1), .INV_R(INV1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel3), .in_ready(ir1), .in_mode(in_mode),
    .in_data(xd[1:0]), .in_tw(td[0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1));

  radix_butterfly_pipe #(.WIDTH(W), .Q(Q), .LOG_R(3), .INV_R(INV3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel3), .in_ready(ir3), .in_mode(in_mode),
    .in_data(xd), .in_tw(td), .out_valid(ov3), .out_ready(out_ready), .out_data(od3));

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_ov();
    return sel3 ? ov3 : ov1;
  endfunction

  function automatic logic cur_ir();
    return sel3 ? ir3 : ir1;
  endfunction

  function automatic logic [8*W-1:0] cur_od();
    logic [7:0][W-1:0] y;
    y = '0;
    if (sel3) y = od3;
    else y[1:0] = od1;
    return y;
  endfunction

  // Behavioural reference written straight from the stage equations.
  function automatic logic [7:0][W-1:0] model(input logic l3, input logic mode,
                                              input logic [7:0][W-1:0] x, input logic [6:0][W-1:0] t);
    longint y[8];
    longint a, b, w, m;
    int l, r, s, d, ia;
    logic [7:0][W-1:0] res;
    l = l3 ? 3 : 1;
    r = 1 << l;
    for (int i = 0; i < 8; i++) y[i] = (i < r) ? longint'(x[i]) : 0;
    for (int p = 0; p < l; p++) begin
      s = mode ? l - 1 - p : p;
      d = r >> (s + 1);
      for (int g = 0; g < (1 << s); g++) begin
        w = longint'(t[(1 << s) - 1 + g]);
        for (int j = 0; j < d; j++) begin
          ia = g * 2 * d + j;
          a = y[ia];
          b = y[ia + d];
          if (!mode) begin
            m = (w * b) % Q;
            y[ia]     = (a + m) % Q;
            y[ia + d] = (a - m + Q) % Q;
          end else begin
            y[ia]     = (a + b) % Q;
            y[ia + d] = (((a - b + Q) % Q) * w) % Q;
          end
        end
      end
    end
    if (EXTRA == 1 && mode)
      for (int i = 0; i < r; i++) y[i] = (y[i] * (l3 ? INV3 : INV1)) % Q;
    for (int i = 0; i < 8; i++) res[i] = y[i][W-1:0];
    return res;
  endfunction

  function automatic vec_t mk(input logic l3, input logic mode, input int x[8], input int t[7], input int y[8]);
    vec_t v;
    v.l3 = l3;
    v.mode = mode;
    for (int i = 0; i < 8; i++) begin
      v.x[i] = x[i][W-1:0];
      v.y[i] = y[i][W-1:0];
    end
    for (int i = 0; i < 7; i++) v.t[i] = t[i][W-1:0];
    return v;
  endfunction

  function automatic vec_t rand_vec(input logic l3);
    vec_t v;
    v = '0;
    v.l3 = l3;
    v.mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < (l3 ? 8 : 2); i++) v.x[i] = W'($urandom_range(0, Q - 1));
    for (int i = 0; i < (l3 ? 7 : 1); i++) v.t[i] = W'($urandom_range(0, Q - 1));
    v.y = model(v.l3, v.mode, v.x, v.t);
    return v;
  endfunction

  // Single beat, free-flowing output: checks acceptance, latency and result.
  task automatic run_vec(input vec_t v, input string name);
    int k;
    @(negedge clk);
    sel3 = v.l3; in_mode = v.mode; xd = v.x; td = v.t; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_int({name, " in_ready"}, int'(cur_ir()), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!cur_ov() && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_int({name, " latency"}, k, (v.l3 ? 6 : 2) + EXTRA);
    check_vec({name, " data"}, cur_od(), v.y);
    @(posedge clk);
  endtask

  vec_t vecs[9];
  vec_t cur;
  logic [7:0][W-1:0] exp_q[$];
  logic [7:0][W-1:0] expv;
  logic [8*W-1:0] prev_od;
  logic prev_stall;
  int sent, cyc, stray;

  initial begin
    vecs[0] = mk(0, 0, '{5,3,0,0,0,0,0,0}, '{2,0,0,0,0,0,0}, '{11,7680,0,0,0,0,0,0});
    vecs[3] = mk(0, 0, '{5,3,0,0,0,0,0,0}, '{1,0,0,0,0,0,0}, '{8,2,0,0,0,0,0,0});
    vecs[4] = mk(0, 0, '{7680,7680,0,0,0,0,0,0}, '{7680,0,0,0,0,0,0}, '{0,7679,0,0,0,0,0,0});
    vecs[6] = mk(1, 0, '{1,0,0,0,0,0,0,0}, '{1,1,1,1,1,1,1}, '{1,1,1,1,1,1,1,1});
    vecs[7] = mk(1, 0, '{7680,1,0,0,0,0,0,0}, '{1,1,1,1,1,1,1}, '{0,7679,0,7679,0,7679,0,7679});
`ifdef RADIX_BUTTERFLY_SCALE_EN
    vecs[1] = mk(0, 1, '{5,3,0,0,0,0,0,0}, '{2,0,0,0,0,0,0}, '{4,2,0,0,0,0,0,0});
    vecs[2] = mk(0, 1, '{5,3,0,0,0,0,0,0}, '{1,0,0,0,0,0,0}, '{4,1,0,0,0,0,0,0});
    vecs[5] = mk(0, 1, '{0,7680,0,0,0,0,0,0}, '{7680,0,0,0,0,0,0}, '{3840,3840,0,0,0,0,0,0});
    vecs[8] = mk(1, 1, '{1,0,0,0,0,0,0,0}, '{1,1,1,1,1,1,1}, '{6721,6721,6721,6721,6721,6721,6721,6721});
`else
    vecs[1] = mk(0, 1, '{5,3,0,0,0,0,0,0}, '{2,0,0,0,0,0,0}, '{8,4,0,0,0,0,0,0});
    vecs[2] = mk(0, 1, '{5,3,0,0,0,0,0,0}, '{1,0,0,0,0,0,0}, '{8,2,0,0,0,0,0,0});
    vecs[5] = mk(0, 1, '{0,7680,0,0,0,0,0,0}, '{7680,0,0,0,0,0,0}, '{7680,7680,0,0,0,0,0,0});
    vecs[8] = mk(1, 1, '{1,0,0,0,0,0,0,0}, '{1,1,1,1,1,1,1}, '{1,1,1,1,1,1,1,1});
`endif

    repeat (2) @(negedge clk);
    check_int("reset out_valid r2", int'(ov1), 0);
    check_int("reset out_valid r8", int'(ov3), 0);
    check_vec("reset out_data r8", od3, '0);
    rst = 1'b0;
    @(negedge clk);
    check_int("reset in_ready r8", int'(ir3), 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Elastic stream with a forced fill window so in_ready must drop.
    sel3 = 1'b1; in_valid = 1'b0; prev_stall = 1'b0; prev_od = '0;
    sent = 0; cyc = 0;
    cur = rand_vec(1'b1);
    while ((sent < 20 || exp_q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      out_ready = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      in_valid  = (sent < 20) && ($urandom_range(0, 4) != 0);
      in_mode = cur.mode; xd = cur.x; td = cur.t;
      #1;
      if (prev_stall) begin
        check_int("stall valid held", int'(ov3), 1);
        check_vec("stall data held", od3, prev_od);
      end
      check_int("stream in_ready", int'(ir3), int'(!(exp_q.size() == CAP3 && !out_ready)));
      if (ov3 && out_ready) begin
        if (exp_q.size() == 0) check_int("stream spurious output", 1, 0);
        else begin
          expv = exp_q.pop_front();
          check_vec("stream data", od3, expv);
        end
      end
      if (in_valid && ir3) begin
        exp_q.push_back(cur.y);
        sent++;
        cur = rand_vec(1'b1);
      end
      prev_stall = ov3 && !out_ready;
      prev_od = od3;
    end
    check_int("stream completed in budget", int'(cyc < 2000), 1);
    check_int("stream beats sent", sent, 20);
    exp_q.delete();

    // Four beats in flight, then a one-cycle reset.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cur = rand_vec(1'b1);
      in_mode = cur.mode; xd = cur.x; td = cur.t; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_int("flight out_valid before reset", int'(ov3), 0);
    rst = 1'b1;
    #1;
    check_int("mid reset out_valid", int'(ov3), 0);
    check_int("mid reset in_ready", int'(ir3), 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov3) stray++;
    end
    check_int("no output after reset", stray, 0);
    run_vec(rand_vec(1'b1), "post reset r8");
    run_vec(rand_vec(1'b0), "post reset r2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
